// File: rtl/seven_seg_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_reader
// Brief    : Recovers digit values from a multiplexed active-low 7-seg bus and
//            presents each complete frame on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [4*NUM_DIGITS-1:0] out_digits,
    output logic                    out_err
);

    localparam int                 c_CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_STABLE = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                    r_state;
    logic [6:0]                r_prev_seg;
    logic [NUM_DIGITS-1:0]     r_prev_en;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [NUM_DIGITS-1:0]     r_errs;
    logic [NUM_DIGITS-1:0]     r_captured;

    logic                      w_onehot;
    logic [c_CNT_W-1:0]        w_cnt_nxt;
    logic                      w_commit;
    logic [4:0]                w_dec;
    logic [4*NUM_DIGITS-1:0]   w_digits_nxt;
    logic [NUM_DIGITS-1:0]     w_errs_nxt;
    logic [NUM_DIGITS-1:0]     w_cap_nxt;
    logic                      w_frame_done;

    // Returns {error, nibble}; unknown patterns map to 4'hF with error set.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        case (s)
            7'h40:   f_decode = 5'h00;
            7'h79:   f_decode = 5'h01;
            7'h24:   f_decode = 5'h02;
            7'h30:   f_decode = 5'h03;
            7'h19:   f_decode = 5'h04;
            7'h12:   f_decode = 5'h05;
            7'h02:   f_decode = 5'h06;
            7'h78:   f_decode = 5'h07;
            7'h00:   f_decode = 5'h08;
            7'h18:   f_decode = 5'h09;
            default: f_decode = 5'h1F;
        endcase
    endfunction

    assign w_onehot = $onehot(dig_en);
    assign w_dec    = f_decode(seg);

    always_comb begin
        w_cnt_nxt = '0;
        if (w_onehot && (dig_en == r_prev_en) && (seg == r_prev_seg)) begin
            w_cnt_nxt = (r_cnt >= c_STABLE) ? c_STABLE : r_cnt + c_ONE;
        end else if (w_onehot) begin
            w_cnt_nxt = c_ONE;
        end
    end

    assign w_commit = w_onehot && (w_cnt_nxt == c_STABLE);

    // First stable value per digit wins; captured digits are never rewritten.
    always_comb begin
        w_digits_nxt = r_digits;
        w_errs_nxt   = r_errs;
        w_cap_nxt    = r_captured;
        if ((r_state == COLLECT) && w_commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_en[i] && !r_captured[i]) begin
                    w_digits_nxt[4*i +: 4] = w_dec[3:0];
                    w_errs_nxt[i]          = w_dec[4];
                    w_cap_nxt[i]           = 1'b1;
                end
            end
        end
    end

    assign w_frame_done = (r_state == COLLECT) && (&w_cap_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_prev_seg <= 7'h7F;
            r_prev_en  <= '0;
            r_cnt      <= '0;
            r_digits   <= '0;
            r_errs     <= '0;
            r_captured <= '0;
            out_val    <= 1'b0;
            out_digits <= '0;
            out_err    <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    r_prev_seg <= seg;
                    r_prev_en  <= dig_en;
                    r_cnt      <= w_cnt_nxt;
                    r_digits   <= w_digits_nxt;
                    r_errs     <= w_errs_nxt;
                    r_captured <= w_cap_nxt;
                    if (w_frame_done) begin
                        r_state    <= HOLD;
                        r_cnt      <= '0;
                        out_val    <= 1'b1;
                        out_digits <= w_digits_nxt;
                        out_err    <= |w_errs_nxt;
                    end
                end
                HOLD: begin
                    r_cnt <= '0;
                    if (out_val && out_rdy) begin
                        r_state    <= COLLECT;
                        r_captured <= '0;
                        out_val    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_reader
// Brief    : Directed and randomized bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_reader;

    localparam int N = 4;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [6:0]   seg = 7'h7F;
    logic [N-1:0] dig_en = '0;
    logic         out_rdy = 1'b1;
    logic         out_val;
    logic [4*N-1:0] out_digits;
    logic         out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .dig_en     (dig_en),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_digits (out_digits),
        .out_err    (out_err)
    );

    logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    // Reference model: tracks run length of identical samples per frame.
    bit             m_val, m_err, m_hold;
    logic [4*N-1:0] m_word;
    logic [3:0]     m_nib [N];
    bit             m_bad [N];
    bit             m_cap [N];
    int             m_run;
    logic [6:0]     m_pseg;
    logic [N-1:0]   m_pen;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int k = 0; k < 10; k++)
            if (codes[k] == s) return {1'b0, 4'(k)};
        return 5'h1F;
    endfunction

    task automatic model_edge();
        int  ones;
        int  idx;
        bit  all_cap;
        logic [4:0] d;
        if (rst) begin
            m_val = 0; m_err = 0; m_hold = 0; m_word = '0; m_run = 0;
            m_pseg = 7'h7F; m_pen = '0;
            for (int k = 0; k < N; k++) m_cap[k] = 0;
        end else if (m_hold) begin
            if (out_rdy) begin
                m_hold = 0; m_val = 0; m_run = 0;
                for (int k = 0; k < N; k++) m_cap[k] = 0;
            end
        end else begin
            ones = $countones(dig_en);
            idx  = 0;
            for (int k = 0; k < N; k++) if (dig_en[k]) idx = k;
            if (ones != 1)                                 m_run = 0;
            else if (dig_en == m_pen && seg == m_pseg)     m_run = m_run + 1;
            else                                           m_run = 1;
            m_pseg = seg;
            m_pen  = dig_en;
            if (ones == 1 && m_run >= S && !m_cap[idx]) begin
                d = ref_decode(seg);
                m_nib[idx] = d[3:0];
                m_bad[idx] = d[4];
                m_cap[idx] = 1;
            end
            all_cap = 1;
            for (int k = 0; k < N; k++) all_cap = all_cap & m_cap[k];
            if (all_cap) begin
                m_hold = 1; m_val = 1; m_err = 0;
                for (int k = 0; k < N; k++) begin
                    m_word[4*k +: 4] = m_nib[k];
                    m_err = m_err | m_bad[k];
                end
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [6:0] s, input logic [N-1:0] e);
        rst = r; seg = s; dig_en = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp("model_out_val",    32'(out_val),    32'(m_val));
        cmp("model_out_digits", 32'(out_digits), 32'(m_word));
        cmp("model_out_err",    32'(out_err),    32'(m_err));
    endtask

    task automatic scan(input int d, input logic [6:0] s, input int n);
        repeat (n) step(1'b0, s, N'(1 << d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*N-1:0] w;
        // Reset with arbitrary inputs
        step(1'b1, 7'($urandom), N'($urandom));
        step(1'b1, 7'($urandom), N'($urandom));
        step(1'b0, 7'h7F, '0);
        cmp("reset_val", 32'(out_val), 32'h0);
        cmp("reset_digits", 32'(out_digits), 32'h0);
        cmp("reset_err", 32'(out_err), 32'h0);

        // Basic frame capture
        out_rdy = 1'b1;
        scan(0, 7'h19, 4); scan(1, 7'h30, 4); scan(2, 7'h24, 4);
        scan(3, 7'h79, 2);
        cmp("frame_val_early", 32'(out_val), 32'h0);
        scan(3, 7'h79, 1);
        cmp("frame_val", 32'(out_val), 32'h1);
        cmp("frame_digits", 32'(out_digits), 32'h1234);
        cmp("frame_err", 32'(out_err), 32'h0);
        scan(3, 7'h79, 1);
        cmp("frame_val_drop", 32'(out_val), 32'h0);

        // Glitch rejection: zero/two-hot enables, then a 2-cycle pattern
        repeat (4) step(1'b0, 7'h19, '0);
        repeat (4) step(1'b0, 7'h40, 4'b0011);
        scan(0, 7'h19, 2); scan(0, 7'h12, 3);
        scan(1, 7'h30, 4); scan(2, 7'h24, 4); scan(3, 7'h79, 3);
        cmp("glitch_val", 32'(out_val), 32'h1);
        cmp("glitch_digit0", 32'(out_digits[3:0]), 32'h5);
        step(1'b0, 7'h7F, '0);

        // Undecodable pattern on digit 2
        scan(0, 7'h19, 4); scan(1, 7'h30, 4); scan(2, 7'h7F, 4); scan(3, 7'h79, 3);
        cmp("invalid_digit2", 32'(out_digits[11:8]), 32'hF);
        cmp("invalid_err", 32'(out_err), 32'h1);
        step(1'b0, 7'h7F, '0);

        // Backpressure
        out_rdy = 1'b0;
        scan(0, 7'h19, 4); scan(1, 7'h30, 4); scan(2, 7'h24, 4); scan(3, 7'h79, 3);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, (k < 3) ? 7'h00 : 7'h78, (k < 3) ? 4'b0001 : 4'b0010);
            cmp("stall_val", 32'(out_val), 32'h1);
            cmp("stall_digits", 32'(out_digits), 32'h1234);
        end
        out_rdy = 1'b1;
        step(1'b0, 7'h78, 4'b0010);
        cmp("release_val", 32'(out_val), 32'h0);
        scan(0, 7'h00, 4); scan(1, 7'h78, 4); scan(2, 7'h02, 4); scan(3, 7'h12, 3);
        cmp("second_val", 32'(out_val), 32'h1);
        cmp("second_digits", 32'(out_digits), 32'h5678);
        step(1'b0, 7'h7F, '0);

        // Mid-frame reset discards partial capture
        scan(0, 7'h19, 4); scan(1, 7'h30, 4); scan(2, 7'h24, 4);
        step(1'b1, 7'h7F, '0);
        scan(3, 7'h79, 4);
        cmp("midreset_val", 32'(out_val), 32'h0);
        step(1'b1, 7'h7F, '0);

        // Decode sweep over all ten values
        for (int f = 0; f < 3; f++) begin
            w = '0;
            for (int d = 0; d < N; d++) begin
                w[4*d +: 4] = 4'((4*f + d) % 10);
                scan(d, codes[(4*f + d) % 10], (d == N-1) ? S : S + 1);
            end
            cmp("sweep_val", 32'(out_val), 32'h1);
            cmp("sweep_digits", 32'(out_digits), 32'(w));
            cmp("sweep_err", 32'(out_err), 32'h0);
            step(1'b0, 7'h7F, '0);
        end

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            int kind;
            int len;
            logic [6:0]   s;
            logic [N-1:0] e;
            kind = $urandom_range(0, 19);
            len  = $urandom_range(1, 5);
            out_rdy = ($urandom_range(0, 3) != 0);
            e = N'(1 << $urandom_range(0, N-1));
            s = codes[$urandom_range(0, 9)];
            if (kind == 0) begin
                step(1'b1, s, e);
            end else begin
                if (kind < 3)  s = 7'($urandom);
                if (kind == 3) e = N'($urandom);
                repeat (len) step(1'b0, s, e);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
